// File: rtl/mat_stream_ctrl.sv
// mat_stream_ctrl: walks a SIZE_A x SIZE_B preloaded matrix buffer in
// row-major or column-major order and streams the elements to a single
// consumer. The buffer has a fixed 1-cycle read latency, so every read is
// tagged at issue time and the returned element lands in a 2-entry output
// FIFO whose head register drives the stream outputs directly.
//
// Stream handshake: an element moves when out_valid && out_ready are both
// high on a rising clk edge. While out_valid is high and out_ready is low,
// out_data, out_last and out_frame_last hold their values; out_valid never
// drops without a handshake (except through reset).
module mat_stream_ctrl #(
   parameter int SIZE_A = 8,
   parameter int SIZE_B = 8,
   parameter int BITS   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   transpose,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd_en,
   output logic [((SIZE_A > 1) ? $clog2(SIZE_A) : 1)-1:0] mem_row,
   output logic [((SIZE_B > 1) ? $clog2(SIZE_B) : 1)-1:0] mem_col,
   input  logic signed [BITS-1:0] mem_rd_data,
   output logic signed [BITS-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   out_frame_last
);

   localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
   localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef struct packed {
      logic [BITS-1:0] data;
      logic            last;
      logic            frame;
   } entry_t;

   logic [1:0]    state_q;
   logic          tr_q;
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;

   logic          inflight_q;
   logic          tag_last_q;
   logic          tag_frame_q;

   logic [1:0]    cnt_q;
   entry_t        head_q;
   entry_t        tail_q;
   entry_t        new_entry;

   logic          pop;
   logic [2:0]    occ;
   logic          rd_en;
   logic          row_end;
   logic          col_end;
   logic          issue_last;
   logic          issue_frame;

   // Issue decision and tags for the address currently presented.
   always_comb begin
      pop         = (cnt_q != 2'd0) && out_ready;
      // Buffered plus in-flight, minus what leaves this cycle; a pop only
      // happens with cnt_q >= 1, so this never underflows.
      occ         = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      rd_en       = (state_q == S_RUN) && (occ < 3'd2);
      row_end     = (row_q == RW'(SIZE_A - 1));
      col_end     = (col_q == CW'(SIZE_B - 1));
      issue_last  = tr_q ? row_end : col_end;
      issue_frame = row_end && col_end;
   end

   // Pass sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         tr_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  tr_q    <= transpose;
               end
            end
            S_RUN: begin
               if (rd_en && issue_frame) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               // Leave once nothing is in flight and the FIFO empties now.
               if (!inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
                  state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Address walk: inner index wraps to 0 and bumps the outer index.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         row_q <= '0;
         col_q <= '0;
      end else if (rd_en) begin
         if (!tr_q) begin
            if (col_end) begin
               col_q <= '0;
               row_q <= row_end ? '0 : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end else begin
            if (row_end) begin
               row_q <= '0;
               col_q <= col_end ? '0 : col_q + CW'(1);
            end else begin
               row_q <= row_q + RW'(1);
            end
         end
      end
   end

   // Read pipeline: remember that a read is outstanding and its tags.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q  <= 1'b0;
         tag_last_q  <= 1'b0;
         tag_frame_q <= 1'b0;
      end else begin
         inflight_q  <= rd_en;
         tag_last_q  <= issue_last;
         tag_frame_q <= issue_frame;
      end
   end

   assign new_entry = '{data: mem_rd_data, last: tag_last_q, frame: tag_frame_q};

   // 2-entry output FIFO; head_q is always the element on the stream.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({inflight_q, pop})
            2'b10: begin
               if (cnt_q == 2'd0) head_q <= new_entry;
               else               tail_q <= new_entry;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               cnt_q  <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  head_q <= new_entry;
               end else begin
                  head_q <= tail_q;
                  tail_q <= new_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign mem_rd_en      = rd_en;
   assign mem_row        = row_q;
   assign mem_col        = col_q;
   assign out_valid      = (cnt_q != 2'd0);
   assign out_data       = head_q.data;
   assign out_last       = head_q.last;
   assign out_frame_last = head_q.frame;

endmodule

// File: tb/tb_mat_stream_ctrl.sv
// Bench for mat_stream_ctrl: a 3x4 instance for directed timing/backpressure/
// restart/reset passes and an 8x8 default instance for random backpressure.
// Both read the same behavioural matrix; the expected element stream is
// built directly from the ordering rules.
module tb_mat_stream_ctrl;

   localparam int BITS = 64;
   localparam int W    = BITS + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, transpose, out_ready, sel;
   int   sz_a, sz_b;
   int   checks, failures;

   logic [BITS-1:0] mem [0:7][0:7];
   logic [W-1:0]    exp_q[$];

   // ---- small 3x4 instance ----
   logic            s_busy, s_done, s_rd_en, s_valid, s_last, s_frame;
   logic [1:0]      s_row, s_col;
   logic [BITS-1:0] s_rd_data, s_data;

   mat_stream_ctrl #(.SIZE_A(3), .SIZE_B(4), .BITS(BITS)) u_small (
      .clk(clk), .reset(reset), .start(start & ~sel), .transpose(transpose),
      .busy(s_busy), .done(s_done), .mem_rd_en(s_rd_en), .mem_row(s_row),
      .mem_col(s_col), .mem_rd_data(s_rd_data), .out_data(s_data),
      .out_valid(s_valid), .out_ready(out_ready), .out_last(s_last),
      .out_frame_last(s_frame)
   );

   // ---- default 8x8 instance ----
   logic            l_busy, l_done, l_rd_en, l_valid, l_last, l_frame;
   logic [2:0]      l_row, l_col;
   logic [BITS-1:0] l_rd_data, l_data;

   mat_stream_ctrl u_large (
      .clk(clk), .reset(reset), .start(start & sel), .transpose(transpose),
      .busy(l_busy), .done(l_done), .mem_rd_en(l_rd_en), .mem_row(l_row),
      .mem_col(l_col), .mem_rd_data(l_rd_data), .out_data(l_data),
      .out_valid(l_valid), .out_ready(out_ready), .out_last(l_last),
      .out_frame_last(l_frame)
   );

   // Matrix buffers with 1-cycle read latency.
   always @(posedge clk) if (s_rd_en) s_rd_data <= mem[s_row][s_col];
   always @(posedge clk) if (l_rd_en) l_rd_data <= mem[l_row][l_col];

   // Selected-instance view.
   logic            busy, done, rd_en, valid, last, frame;
   logic [BITS-1:0] data;
   assign busy  = sel ? l_busy  : s_busy;
   assign done  = sel ? l_done  : s_done;
   assign rd_en = sel ? l_rd_en : s_rd_en;
   assign valid = sel ? l_valid : s_valid;
   assign last  = sel ? l_last  : s_last;
   assign frame = sel ? l_frame : s_frame;
   assign data  = sel ? l_data  : s_data;

   task automatic check(input string tag, input logic [BITS-1:0] got,
                        input logic [BITS-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic fill_mem(input bit random);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            mem[r][c] = random ? {$urandom, $urandom} : BITS'(16 * r + c);
   endtask

   // Expected stream straight from the order rules.
   task automatic build_expected(input logic tr);
      exp_q.delete();
      if (!tr) begin
         for (int r = 0; r < sz_a; r++)
            for (int c = 0; c < sz_b; c++)
               exp_q.push_back({mem[r][c], c == sz_b - 1, (r == sz_a - 1) && (c == sz_b - 1)});
      end else begin
         for (int c = 0; c < sz_b; c++)
            for (int r = 0; r < sz_a; r++)
               exp_q.push_back({mem[r][c], r == sz_a - 1, (r == sz_a - 1) && (c == sz_b - 1)});
      end
   endtask

   // mode 0: ready always 1 (exact timing checked); 1: ready low in cycles
   // 4..9; 2: random ready. restart pulses start with toggled transpose at
   // cycle 6. rst_at >= 0 asserts reset during that cycle.
   task automatic run_pass(input logic tr, input int mode, input bit restart,
                           input int rst_at);
      int n, hs, last_hs_k, done_k, held;
      bit done_seen, stall_prev, pop, finished;
      logic [W-1:0] e, e1, prev;
      n = sz_a * sz_b;
      build_expected(tr);
      e1 = exp_q[1];
      hs = 0; last_hs_k = -1; done_k = -1; held = 0;
      done_seen = 0; stall_prev = 0; finished = 0; prev = '0;
      @(posedge clk); #1;
      for (int k = 0; k < 1000 && !finished; k++) begin
         reset     = (k == rst_at);
         start     = (k == 0) || (restart && k == 6);
         transpose = (k == 6) ? ~tr : tr;
         out_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? !(k >= 4 && k <= 9) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (rst_at >= 0 && k > rst_at) begin
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rd_en", rd_en, 0);
            if (k == rst_at + 4) finished = 1;
         end else begin
            pop = valid && out_ready;
            if (k >= 1 && !done_seen) check("busy_high", busy, 1);
            if (mode == 0) begin
               check("valid_timing", valid, (k >= 3) && (k <= n + 2));
               check("rd_en_timing", rd_en, (k >= 1) && (k <= n));
               check("done_timing", done, k == n + 3);
            end
            if (stall_prev) begin
               check("hold_valid", valid, 1);
               check("hold_data", data, prev[W-1:2]);
               check("hold_tags", {last, frame}, prev[1:0]);
            end
            if (mode == 1 && k == 9) check("frozen_elem1", data, e1[W-1:2]);
            if (rd_en) check("occupancy_ok", (held - int'(pop)) < 2, 1);
            if (pop) begin
               if (exp_q.size() == 0) begin
                  check("extra_element", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("data", data, e[W-1:2]);
                  check("last", last, e[1]);
                  check("frame_last", frame, e[0]);
                  hs++;
                  last_hs_k = k;
               end
            end
            if (done_seen && k == done_k + 1) begin
               check("busy_after_done", busy, 0);
               check("done_pulse_width", done, 0);
               finished = 1;
            end else if (done) begin
               check("done_after_last_hs", k, last_hs_k + 1);
               check("element_count", hs, n);
               done_seen = 1;
               done_k = k;
            end
            held = held + int'(rd_en) - int'(pop);
            stall_prev = valid && !out_ready;
            prev = {data, last, frame};
         end
         if (!finished && k == 999) check("timeout", 1, 0);
         @(posedge clk); #1;
      end
      reset = 0;
      start = 0;
      out_ready = 0;
   endtask

   initial begin
      checks = 0; failures = 0;
      sel = 0; sz_a = 3; sz_b = 4;
      reset = 1; start = 0; transpose = 0; out_ready = 0;
      fill_mem(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", s_busy, 0);
      check("reset_done", s_done, 0);
      check("reset_valid", s_valid, 0);
      check("reset_rd_en", s_rd_en, 0);
      check("reset_data", s_data, 0);
      check("reset_tags", {s_last, s_frame}, 0);
      check("reset_addr", {s_row, s_col}, 0);
      check("reset_busy_8x8", l_busy, 0);
      check("reset_valid_8x8", l_valid, 0);
      @(posedge clk); #1;
      reset = 0;

      run_pass(0, 0, 0, -1);   // row-major, full throughput
      run_pass(1, 0, 0, -1);   // column-major
      run_pass(0, 1, 0, -1);   // backpressure window
      run_pass(0, 0, 1, -1);   // ignored restart with toggled transpose
      run_pass(0, 0, 0, -1);   // fresh pass after done
      run_pass(0, 0, 0, 7);    // mid-stream reset
      run_pass(0, 0, 0, -1);   // restart from (0,0) after reset
      fill_mem(1);
      for (int i = 0; i < 3; i++) run_pass(1'($urandom_range(0, 1)), 2, 0, -1);

      sel = 1; sz_a = 8; sz_b = 8;
      fill_mem(1);
      run_pass(0, 2, 0, -1);
      run_pass(1, 2, 0, -1);
      run_pass(1, 0, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
